// File: rtl/delay_pkg.sv
// delay_pkg: shared state encoding and default sizes for the delay line controller
package delay_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam int DATA_WIDTH_DEF = 9;
  localparam int ADDR_WIDTH_DEF = 8;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: W-bit pointer that advances on inc and wraps modulo 2**W
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  // natural binary overflow provides the modulo wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc) q <= q + 1'b1;
endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: drives a two-port sample RAM as a circular delay line (DELAY_FILL_ZERO_EN emits zeros while filling)
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  filling,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, offset_q;
  logic [ADDR_WIDTH:0] fill_cnt, fill_d;
  logic accept, load;
  assign accept = en & in_valid & (state != IDLE);
  assign load = en & ((state == IDLE) | (offset != offset_q));
  assign fill_d = (offset_q == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, offset_q};
  assign filling = state == FILL;
  assign ram_wr_en = accept;
  assign ram_wr_addr = wr_ptr;
  assign ram_din = in_data;
  assign ram_rd_en = accept & (state == RUN);
  assign ram_rd_addr = wr_ptr - offset_q;
  wrap_counter #(.W(ADDR_WIDTH)) u_wr_ptr (
    .clk(clk),
    .rst_n(rst_n),
    .inc(accept),
    .q(wr_ptr)
  );
  // dropping en wins, then an offset change (re)starts a fill, then a completed fill enters RUN
  always_comb
    state_n = !en ? IDLE
            : load ? FILL
            : (filling && accept && (fill_cnt + 1'b1 == fill_d)) ? RUN
            : state;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // capture the delay and count accepts until D samples are in the buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      offset_q <= '0;
      fill_cnt <= '0;
    end else begin
      if (load) offset_q <= offset;
      if (!en || load) fill_cnt <= '0;
      else if (filling && accept) fill_cnt <= fill_cnt + 1'b1;
    end
`ifdef DELAY_FILL_ZERO_EN
  logic zero_q;
  assign out_data = zero_q ? '0 : ram_dout;
  // each fill-phase accept yields a zero sample so the output rate matches the input rate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      out_valid <= ram_rd_en | (accept & filling);
      zero_q <= accept & filling;
    end
`else
  assign out_data = ram_dout;
  // output valid tracks the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_valid <= 1'b0;
    else out_valid <= ram_rd_en;
`endif
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: directed stimulus against a sample-history model of the delay line
module tb_delay_line_ctrl;
  localparam int DW = 9;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0, en = 0, in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] offset = '0;
  logic out_valid, filling, ram_wr_en, ram_rd_en;
  logic [DW-1:0] out_data, ram_din, ram_dout;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] mem [0:DEPTH-1];
  int n_cmp = 0, n_bad = 0;
  int hist [0:4095];
  int n_acc = 0;
  int m_phase = 0, m_cnt = 0, m_offq = 0, m_ptr = 0;
  int exp_ov = 0, exp_od = 0;
  int md, macc, mrd, cd, cacc;
  int got [$];

  delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .offset(offset), .out_valid(out_valid), .out_data(out_data), .filling(filling),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_offq = 0; m_ptr = 0; exp_ov = 0; exp_od = 0;
    end else begin
      md = (m_offq == 0) ? DEPTH : m_offq;
      macc = int'(en && in_valid && m_phase != 0);
      mrd = int'(macc != 0 && m_phase == 2);
      exp_ov = mrd;
`ifdef DELAY_FILL_ZERO_EN
      if (macc != 0 && m_phase == 1) exp_ov = 1;
`endif
      exp_od = (mrd != 0) ? hist[n_acc - md] : 0;
      if (macc != 0) begin
        hist[n_acc] = int'(in_data);
        n_acc++;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (m_phase == 0) begin
        if (en) begin m_phase = 1; m_offq = int'(offset); m_cnt = 0; end
      end else if (!en) begin
        m_phase = 0; m_cnt = 0;
      end else if (int'(offset) != m_offq) begin
        m_phase = 1; m_offq = int'(offset); m_cnt = 0;
      end else if (m_phase == 1 && macc != 0) begin
        m_cnt++;
        if (m_cnt == md) m_phase = 2;
      end
    end
  end

  always begin
    @(negedge clk);
    if (rst_n) begin
      cd = (m_offq == 0) ? DEPTH : m_offq;
      cacc = int'(en && in_valid && m_phase != 0);
      chk("out_valid", int'(out_valid), exp_ov);
      if (exp_ov != 0 && out_valid) chk("out_data", int'(out_data), exp_od);
      if (out_valid) got.push_back(int'(out_data));
      chk("filling", int'(filling), int'(m_phase == 1));
      chk("ram_wr_en", int'(ram_wr_en), cacc);
      chk("ram_rd_en", int'(ram_rd_en), int'(cacc != 0 && m_phase == 2));
      if (cacc != 0) begin
        chk("ram_wr_addr", int'(ram_wr_addr), m_ptr);
        chk("ram_din", int'(ram_din), int'(in_data));
      end
      if (cacc != 0 && m_phase == 2) chk("ram_rd_addr", int'(ram_rd_addr), (m_ptr - cd + DEPTH) % DEPTH);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic feed(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = DW'(base + i); tick();
      if (gaps) begin in_valid = 0; tick(); end
    end
    in_valid = 0;
    tick(3);
  endtask

  task automatic check_run(input string nm, input int n, input int d, input int base);
    int lead;
`ifdef DELAY_FILL_ZERO_EN
    lead = d;
`else
    lead = 0;
`endif
    chk({nm, "_count"}, got.size(), n - d + lead);
    if (got.size() > lead) chk({nm, "_first"}, got[lead], base);
    if (got.size() > 0) chk({nm, "_last"}, got[got.size() - 1], (n - d > 0) ? base + n - d - 1 : 0);
    if (lead > 0 && got.size() > 0) chk({nm, "_lead_zero"}, got[0], 0);
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_filling", int'(filling), 0);
    chk("rst_wr_en", int'(ram_wr_en), 0);
    chk("rst_rd_en", int'(ram_rd_en), 0);
    rst_n = 1;
    tick(2);
    chk("idle_wr_addr", int'(ram_wr_addr), 0);
    offset = 4; en = 1; tick();
    chk("fill_entered", int'(filling), 1);
    feed(10, 1, 0);
    check_run("off4", 10, 4, 1);
    offset = 3; tick();
    feed(12, 100, 1);
    check_run("off3_gaps", 12, 3, 100);
    offset = 0; tick();
    feed(40, 200, 0);
    check_run("off0_wrap", 40, 16, 200);
    offset = 4; tick();
    feed(8, 300, 0);
    check_run("off4_again", 8, 4, 300);
    offset = 2; tick();
    feed(6, 400, 0);
    check_run("off2_refill", 6, 2, 400);
    en = 0; in_valid = 1; in_data = 9'd77;
    tick(5);
    chk("en_low_wr_en", int'(ram_wr_en), 0);
    in_valid = 0; en = 1; tick();
    feed(6, 450, 0);
    check_run("en_restore", 6, 2, 450);
    in_valid = 1; in_data = 9'd480; tick();
    in_data = 9'd481; tick();
    in_data = 9'd482; tick();
    chk("pre_rst_out_valid", int'(out_valid), 1);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_filling", int'(filling), 0);
    chk("mid_rst_wr_en", int'(ram_wr_en), 0);
    in_valid = 0;
    tick(2);
    rst_n = 1;
    got.delete();
    tick();
    feed(6, 500, 0);
    check_run("after_rst", 6, 2, 500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
